// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: request side (in_*) and result side (out_*).
// The unit takes the slave view; the producer/consumer pair takes the master view.
interface imm_ext_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [2:0]       in_mode;
    logic [OUT_W-1:0] in_pc;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             out_err;
    logic [2:0]       count;

    modport master (
        output in_valid, in_imm, in_mode, in_pc, out_ready,
        input  in_ready, out_valid, out_imm, out_err, count
    );

    modport slave (
        input  in_valid, in_imm, in_mode, in_pc, out_ready,
        output in_ready, out_valid, out_imm, out_err, count
    );
endinterface

// File: rtl/imm_ext_pipe.sv
// Registered immediate extension with a DEPTH-entry result buffer.
// Define IMM_EXT_BTA_EN to build the mode-100 branch-target adder.
module imm_ext_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    imm_ext_pipe_if.slave bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [OUT_W-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] err_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [2:0]       count_q;

    logic             push;
    logic             pop;
    logic [OUT_W-1:0] zx;
    logic [OUT_W-1:0] sx;
    logic [OUT_W-1:0] lx;
    logic [OUT_W-1:0] bx;
    logic [OUT_W-1:0] res;
    logic             res_err;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign zx = OUT_W'(bus.in_imm);
    assign sx = OUT_W'($signed(bus.in_imm));
    assign lx = zx << (OUT_W - IN_W);
    assign bx = sx << 2;

`ifdef IMM_EXT_BTA_EN
    logic [OUT_W-1:0] tx;
    assign tx = bus.in_pc + bx;
`else
    logic unused_pc;
    assign unused_pc = ^bus.in_pc;
`endif

    always_comb begin
        res     = '0;
        res_err = 1'b0;
        unique case (bus.in_mode)
            3'b000: res = zx;
            3'b001: res = sx;
            3'b010: res = lx;
            3'b011: res = bx;
`ifdef IMM_EXT_BTA_EN
            3'b100: res = tx;
`endif
            default: begin
                res     = '0;
                res_err = 1'b1;
            end
        endcase
    end

    // in_ready looks only at the registered count, so a full buffer
    // refuses a push even while the head is being popped.
    assign bus.in_ready  = (count_q < DEPTH_C);
    assign bus.out_valid = (count_q != 3'd0);
    assign bus.out_imm   = bus.out_valid ? data_q[rd_ptr] : '0;
    assign bus.out_err   = bus.out_valid ? err_q[rd_ptr] : 1'b0;
    assign bus.count     = count_q;

    assign push = bus.in_valid && bus.in_ready;
    assign pop  = bus.out_valid && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                data_q[wr_ptr] <= res;
                err_q[wr_ptr]  <= res_err;
                wr_ptr         <= nxt(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nxt(rd_ptr);
            end
            unique case ({push, pop})
                2'b10:   count_q <= count_q + 3'd1;
                2'b01:   count_q <= count_q - 3'd1;
                default: count_q <= count_q;
            endcase
        end
    end
endmodule
